memory: RTL and testbench



---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_clear_seq.sv | 29 ++
 rtl/memory.sv | 56 +++++
 tb/tb_memory.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory geometry defaults (also used by cpu) and the
// memory controller's state encoding.
package mem_pkg;
  localparam int MEM_ADDR_WIDTH = 6;
  localparam int MEM_DATA_WIDTH = 16;
  localparam logic MEM_ST_CLEAR = 1'b0;
  localparam logic MEM_ST_RUN   = 1'b1;
endpackage

// File: rtl/mem_clear_seq.sv
// mem_clear_seq: post-reset sweep that writes zero to every word, then parks in RUN.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr
);
  logic                state;
  logic [ADDR_WIDTH:0] cnt;
  logic                done;
  assign busy    = state == MEM_ST_CLEAR;
  assign wr_en   = busy;
  assign wr_addr = cnt[ADDR_WIDTH-1:0];
  assign done    = busy && &cnt[ADDR_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEM_ST_CLEAR;
      cnt   <= '0;
    end else if (busy) begin
      cnt   <= cnt + 1'b1;
      state <= done ? MEM_ST_RUN : MEM_ST_CLEAR;
    end
  end
endmodule

// File: rtl/memory.sv
// memory: single-port synchronous memory with read-first CPU port and loader port.
// Define MEM_CLEAR_EN to zero the array with a sweep after every reset.
module memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ld_fire;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
`ifdef MEM_CLEAR_EN
  mem_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .wr_en   (clr_we),
    .wr_addr (clr_addr)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif
  assign ld_ready = ~busy;
  // Sweep owns the write port while busy; otherwise the loader beats the CPU.
  always_comb begin
    ld_fire = ld_valid && ld_ready;
    wr_en   = clr_we || ld_fire || (we && !busy);
    wr_addr = clr_we ? clr_addr : ld_fire ? ld_addr : addr;
    wr_data = clr_we ? '0 : ld_fire ? ld_data : data;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else out <= busy ? '0 : mem[addr];
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: scoreboard bench for memory; read expectations are queued as each
// address is presented and checked one edge later.
module tb_memory;
  localparam int AW = 6;
  localparam int DW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] out;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          busy;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  int tests = 0;
  int fails = 0;

  memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy falls (bounded) and flags ld_ready/out misbehaviour while busy.
  task automatic sweep_len(output int n, output logic bad);
    n = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (ld_ready !== 1'b0 || out !== '0) bad = 1'b1;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    logic exp_busy;
    rst_n = 1'b0;
    step();
    step();
`ifdef MEM_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    tests++;
    if (out !== '0) begin fails++; $display("FAIL reset_out: got %h want 0000", out); end
    tests++;
    if (busy !== exp_busy) begin fails++; $display("FAIL reset_busy: got %b want %b", busy, exp_busy); end
    tests++;
    if (ld_ready !== ~exp_busy) begin fails++; $display("FAIL reset_ld_ready: got %b want %b", ld_ready, ~exp_busy); end
    rst_n = 1'b1;
`ifdef MEM_CLEAR_EN
    sweep_len(n, bad);
    tests++;
    if (n != 64) begin fails++; $display("FAIL sweep_len: got %0d cycles want 64", n); end
    tests++;
    if (bad) begin fails++; $display("FAIL sweep_outputs: got ld_ready/out active want 0 while busy"); end
    for (int i = 0; i < 3; i++) begin
      addr = (i == 0) ? 6'd0 : (i == 1) ? 6'd31 : 6'd63;
      exp_q.push_back(16'h0000);
      step();
      e = exp_q.pop_front();
      tests++;
      if (out !== e) begin fails++; $display("FAIL clear_read[%0d]: got %h want %h", addr, out, e); end
    end
`endif
  endtask

  task automatic test_midsweep();
`ifdef MEM_CLEAR_EN
    int n;
    logic bad;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (20) step();
    ld_valid = 1'b1;
    ld_addr  = 6'd10;
    ld_data  = 16'h1234;
    rst_n = 1'b0;
    #2;
    tests++;
    if (busy !== 1'b1 || ld_ready !== 1'b0) begin
      fails++; $display("FAIL midsweep_reset: got busy=%b ld_ready=%b want 1/0", busy, ld_ready);
    end
    step();
    rst_n = 1'b1;
    sweep_len(n, bad);
    ld_valid = 1'b0;
    tests++;
    if (n != 64) begin fails++; $display("FAIL midsweep_len: got %0d cycles want 64", n); end
    tests++;
    if (bad) begin fails++; $display("FAIL midsweep_ld_ready: got ld_ready/out active want 0 while busy"); end
    addr = 6'd10;
    exp_q.push_back(16'h0000);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL midsweep_loader_ignored: got %h want %h", out, e); end
`endif
  endtask

  task automatic test_loader();
    tests++;
    if (ld_ready !== 1'b1) begin fails++; $display("FAIL loader_ready: got %b want 1", ld_ready); end
    ld_valid = 1'b1;
    ld_addr = 6'd8;
    ld_data = 16'h7300;
    step();
    ld_addr = 6'd9;
    ld_data = 16'h8300;
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr = 6'(8 + i);
      exp_q.push_back(i == 0 ? 16'h7300 : 16'h8300);
      step();
      e = exp_q.pop_front();
      tests++;
      if (out !== e) begin fails++; $display("FAIL loader_read[%0d]: got %h want %h", addr, out, e); end
    end
  endtask

  task automatic test_cpu_rw();
    we = 1'b1;
    addr = 6'd3;
    data = 16'hBEEF;
    step();
    we = 1'b0;
    exp_q.push_back(16'hBEEF);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL cpu_rw: got %h want %h", out, e); end
  endtask

  task automatic test_read_during_write();
    we = 1'b1;
    addr = 6'd5;
    data = 16'h1111;
    step();
    data = 16'h2222;
    exp_q.push_back(16'h1111);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL rdw_old: got %h want %h", out, e); end
    we = 1'b0;
    exp_q.push_back(16'h2222);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL rdw_new: got %h want %h", out, e); end
  endtask

  task automatic test_collision();
    we = 1'b1;
    addr = 6'd4;
    data = 16'h0404;
    step();
    data = 16'h5555;
    ld_valid = 1'b1;
    ld_addr = 6'd4;
    ld_data = 16'hAAAA;
    exp_q.push_back(16'h0404);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL collision_read_first: got %h want %h", out, e); end
    we = 1'b0;
    ld_valid = 1'b0;
    exp_q.push_back(16'hAAAA);
    step();
    e = exp_q.pop_front();
    tests++;
    if (out !== e) begin fails++; $display("FAIL collision_loader_wins: got %h want %h", out, e); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'($urandom);
      we = 1'b1;
      addr = 6'(32 + i);
      data = vals[i];
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = 6'(32 + i);
      exp_q.push_back(vals[i]);
      step();
      e = exp_q.pop_front();
      tests++;
      if (out !== e) begin fails++; $display("FAIL b2b_read[%0d]: got %h want %h", addr, out, e); end
    end
  endtask

  initial begin
    test_reset();
    test_midsweep();
    test_loader();
    test_cpu_rw();
    test_read_during_write();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
